// File: rtl/writeback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_ctrl
//  Brief    : Instruction sequencer for writeback_top. Sweeps the register
//             bank to zero after reset, then runs one load-immediate or ALU
//             instruction at a time through READ/WRITE phases and returns
//             the written value on a response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_ctrl #(
   parameter int WIDTH = 4,
   parameter int NREG  = 3,
   parameter int NOPER = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_ld,
   input  logic [NOPER-1:0] in_op,
   input  logic [NREG-1:0]  in_rd,
   input  logic [NREG-1:0]  in_rs1,
   input  logic [NREG-1:0]  in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [NREG-1:0]  out_rd,
   output logic [7:0]       retired_cnt,
   output logic             clear_busy,
   output logic [NREG-1:0]  reg_addr1,
   output logic [NREG-1:0]  reg_addr2,
   output logic [NREG-1:0]  reg_addr3,
   output logic [WIDTH-1:0] data,
   output logic [NOPER-1:0] oper,
   output logic             sel,
   output logic             write_en,
   input  logic [WIDTH-1:0] r_out
);

   // Sweep counter is one bit wider than a register address
   localparam logic [NREG:0] C_LAST = {1'b0, {NREG{1'b1}}};
   localparam logic [NREG:0] C_ONE  = {{NREG{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [NREG:0]      r_cnt;
   logic               r_ld;
   logic [NOPER-1:0]   r_op;
   logic [NREG-1:0]    r_rd;
   logic [NREG-1:0]    r_rs1;
   logic [NREG-1:0]    r_rs2;
   logic [WIDTH-1:0]   r_imm;
   logic [WIDTH-1:0]   r_out_data;
   logic [NREG-1:0]    r_out_rd;
   logic [7:0]         r_retired;

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_clear_busy;
   logic [NREG-1:0]    w_addr3;
   logic [WIDTH-1:0]   w_data;
   logic [NOPER-1:0]   w_oper;
   logic               w_sel;
   logic               w_write_en;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_CLEAR;
      else     r_state <= w_next;
   end

   // Next-state decode and Moore datapath controls
   always_comb begin
      w_next       = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_clear_busy = 1'b0;
      w_addr3      = '0;
      w_data       = '0;
      w_oper       = '0;
      w_sel        = 1'b0;
      w_write_en   = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_write_en   = 1'b1;
            w_sel        = 1'b1;
            w_addr3      = r_cnt[NREG-1:0];
            w_clear_busy = 1'b1;
            if (r_cnt == C_LAST) w_next = S_IDLE;
         end
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next = S_READ;
         end
         S_READ: begin
            w_oper = r_op;
            w_next = S_WRITE;
         end
         S_WRITE: begin
            w_oper     = r_op;
            w_addr3    = r_rd;
            w_sel      = r_ld;
            w_data     = r_ld ? r_imm : '0;
            w_write_en = 1'b1;
            w_next     = S_RESP;
         end
         S_RESP: begin
            w_out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_CLEAR;
      endcase
   end

   // Sweep counter, instruction capture, result capture and retire count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_ld       <= 1'b0;
         r_op       <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_imm      <= '0;
         r_out_data <= '0;
         r_out_rd   <= '0;
         r_retired  <= '0;
      end else begin
         if (r_state == S_CLEAR) r_cnt <= r_cnt + C_ONE;
         if (r_state == S_IDLE && in_valid) begin
            r_ld  <= in_ld;
            r_op  <= in_op;
            r_rd  <= in_rd;
            r_rs1 <= in_rs1;
            r_rs2 <= in_rs2;
            r_imm <= in_imm;
         end
         // r_out is still the pre-write value during WRITE
         if (r_state == S_WRITE) begin
            r_out_data <= r_ld ? r_imm : r_out;
            r_out_rd   <= r_rd;
         end
         if (r_state == S_RESP && out_ready) r_retired <= r_retired + 8'd1;
      end
   end

   // Every output is forced low while reset is held
   assign in_ready    = w_in_ready   & ~rst;
   assign out_valid   = w_out_valid  & ~rst;
   assign clear_busy  = w_clear_busy & ~rst;
   assign write_en    = w_write_en   & ~rst;
   assign sel         = w_sel        & ~rst;
   assign reg_addr3   = rst ? '0 : w_addr3;
   assign data        = rst ? '0 : w_data;
   assign oper        = rst ? '0 : w_oper;
   assign reg_addr1   = rst ? '0 : r_rs1;
   assign reg_addr2   = rst ? '0 : r_rs2;
   assign out_data    = rst ? '0 : r_out_data;
   assign out_rd      = rst ? '0 : r_out_rd;
   assign retired_cnt = rst ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_ctrl
//  Brief    : Self-checking bench for writeback_ctrl with a behavioural model
//             of the writeback_top register bank and ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_ready, in_ld = 1'b0;
   logic [2:0] in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [3:0] in_imm = '0;
   logic       out_valid, out_ready = 1'b1;
   logic [3:0] out_data;
   logic [2:0] out_rd;
   logic [7:0] retired_cnt;
   logic       clear_busy;
   logic [2:0] reg_addr1, reg_addr2, reg_addr3;
   logic [3:0] data;
   logic [2:0] oper;
   logic       sel, write_en;
   logic [3:0] r_out;

   int total = 0;
   int bad   = 0;

   writeback_ctrl #(.WIDTH(4), .NREG(3), .NOPER(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .retired_cnt(retired_cnt), .clear_busy(clear_busy),
      .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .reg_addr3(reg_addr3),
      .data(data), .oper(oper), .sel(sel), .write_en(write_en), .r_out(r_out)
   );

   always #5 clk = ~clk;

   // ALU of the surrounding datapath (environment definition)
   function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return a + b;
         3'd4:    return a - b;
         3'd5:    return ~a;
         3'd6:    return {a[2:0], 1'b0};
         default: return b;
      endcase
   endfunction

   // Register bank of writeback_top, written through the DUT's controls
   logic [3:0] bank [8];
   assign r_out = alu(oper, bank[reg_addr1], bank[reg_addr2]);
   always @(posedge clk) if (write_en) bank[reg_addr3] <= sel ? data : r_out;

   // Architectural reference: register contents and retire count
   logic [3:0] ref_rf [8];
   int         exp_ret = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Hold reset for ncyc edges, then check the full 8-address sweep
   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         #1;
         chk("rst_ctl_zero", {write_en, clear_busy, in_ready, out_valid, sel, oper, data, reg_addr3}, 0);
         chk("rst_dat_zero", {out_data, out_rd, retired_cnt, reg_addr1, reg_addr2}, 0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("sweep_we", write_en, 1);
         chk("sweep_addr", reg_addr3, i);
         chk("sweep_data_sel", {data, sel}, 5'b0000_1);
         chk("sweep_busy_rdy", {clear_busy, in_ready}, 2'b10);
         @(posedge clk); #1;
      end
      chk("sweep_done", {in_ready, clear_busy, write_en}, 3'b100);
      chk("rst_retired", retired_cnt, 0);
      for (int i = 0; i < 8; i++) ref_rf[i] = '0;
      exp_ret = 0;
   endtask

   // One instruction from acceptance to retirement; bp = RESP cycles with out_ready low
   task automatic run_instr(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic [3:0] imm, input logic [3:0] exp, input int bp);
      int n;
      logic [7:0] ret0;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", in_ready, 1);
      if (in_ready !== 1'b1) return;
      chk("idle_no_valid", out_valid, 0);
      ret0 = retired_cnt;
      in_valid = 1'b1; in_ld = ld; in_op = op; in_rd = rd;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_ld = 1'($urandom); in_op = 3'($urandom); in_rd = 3'($urandom);
      in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_imm = 4'($urandom);
      out_ready = (bp == 0);
      chk("read_addrs", {reg_addr1, reg_addr2}, {rs1, rs2});
      chk("read_oper", oper, op);
      chk("read_we_rdy", {write_en, in_ready, out_valid}, 0);
      @(posedge clk); #1;
      chk("write_we", write_en, 1);
      chk("write_addr3", reg_addr3, rd);
      chk("write_sel", sel, ld);
      chk("write_data", data, ld ? imm : 4'h0);
      chk("write_src", {reg_addr1, reg_addr2, oper}, {rs1, rs2, op});
      @(posedge clk); #1;
      chk("resp_valid", out_valid, 1);
      chk("resp_data", out_data, exp);
      chk("resp_rd", out_rd, rd);
      chk("resp_no_we_rdy", {write_en, in_ready}, 0);
      for (int k = 1; k < bp; k++) begin
         @(posedge clk); #1;
         chk("bp_hold", {out_valid, out_data, out_rd}, {1'b1, exp, rd});
         chk("bp_quiet", {write_en, in_ready}, 0);
         chk("bp_retired", retired_cnt, ret0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      exp_ret = (exp_ret + 1) % 256;
      chk("retired", retired_cnt, exp_ret);
      chk("back_idle", {in_ready, out_valid}, 2'b10);
      ref_rf[rd] = exp;
   endtask

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [3:0] imm;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic       ld;
      logic [2:0] op, rd, rs1, rs2;
      logic [3:0] imm, e;

      // Directed vectors, executed in order from a freshly cleared bank
      tbl[0] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 4'hA, 4'hA}; // load r2=A
      tbl[1] = '{1'b1, 3'd7, 3'd1, 3'd3, 3'd4, 4'h5, 4'h5}; // load r1=5
      tbl[2] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 4'h3, 4'h3}; // load r2=3
      tbl[3] = '{1'b0, 3'd0, 3'd4, 3'd1, 3'd2, 4'hF, 4'h1}; // r4 = 5 & 3
      tbl[4] = '{1'b0, 3'd1, 3'd6, 3'd4, 3'd0, 4'h0, 4'h1}; // r6 = r4 | r0
      tbl[5] = '{1'b0, 3'd3, 3'd7, 3'd1, 3'd2, 4'h0, 4'h8}; // r7 = 5 + 3
      tbl[6] = '{1'b0, 3'd4, 3'd3, 3'd2, 3'd1, 4'h0, 4'hE}; // r3 = 3 - 5
      tbl[7] = '{1'b0, 3'd2, 3'd1, 3'd1, 3'd1, 4'h0, 4'h0}; // r1 = r1 ^ r1
      tbl[8] = '{1'b0, 3'd3, 3'd0, 3'd7, 3'd3, 4'h0, 4'h6}; // r0 = 8 + E
      tbl[9] = '{1'b0, 3'd5, 3'd5, 3'd0, 3'd2, 4'h0, 4'h9}; // r5 = ~6

      do_reset(2);

      for (int i = 0; i < 10; i++)
         run_instr(tbl[i].ld, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].exp, 0);

      // Backpressure: three RESP cycles with out_ready low
      run_instr(1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 4'h7, 4'h7, 3);
      // Confirm the ALU path reads the backpressured write: r2 = r3 + r0 = 7 + 6
      run_instr(1'b0, 3'd3, 3'd2, 3'd3, 3'd0, 4'h0, 4'hD, 0);

      // Reset during WRITE: instruction dropped, no response, sweep restarts
      in_valid = 1'b1; in_ld = 1'b1; in_op = 3'd0; in_rd = 3'd6; in_imm = 4'h5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_write_we", write_en, 1);
      do_reset(2);
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_no_resp", {out_valid, in_ready}, 2'b01);
         @(posedge clk); #1;
      end

      // Randomized instructions against the reference model; 256 retires wrap the count
      for (int i = 0; i < 256; i++) begin
         ld  = 1'($urandom);
         op  = 3'($urandom);
         rd  = 3'($urandom);
         rs1 = 3'($urandom);
         rs2 = 3'($urandom);
         imm = 4'($urandom);
         e   = ld ? imm : alu(op, ref_rf[rs1], ref_rf[rs2]);
         run_instr(ld, op, rd, rs1, rs2, imm, e, 0);
      end
      chk("retired_wrap", retired_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
